// File: rtl/hazard5_ahbl_arbiter_if.sv
// Bus bundle for hazard5_ahbl_arbiter: N_PORTS upstream AHB-Lite masters plus one downstream slave port.
// The arbiter takes the slave modport; the surrounding system (masters and downstream slave) takes master.
interface hazard5_ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) ();
    logic [N_PORTS*W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]        src_hwrite;
    logic [2*N_PORTS-1:0]      src_htrans;
    logic [3*N_PORTS-1:0]      src_hsize;
    logic [4*N_PORTS-1:0]      src_hprot;
    logic [N_PORTS*W_DATA-1:0] src_hwdata;
    logic [N_PORTS-1:0]        src_hready;
    logic [N_PORTS-1:0]        src_hresp;
    logic [W_DATA-1:0]         src_hrdata;

    logic [W_ADDR-1:0]         dst_haddr;
    logic                      dst_hwrite;
    logic [1:0]                dst_htrans;
    logic [2:0]                dst_hsize;
    logic [3:0]                dst_hprot;
    logic [2:0]                dst_hburst;
    logic                      dst_hmastlock;
    logic [W_DATA-1:0]         dst_hwdata;
    logic                      dst_hready;
    logic                      dst_hresp;
    logic [W_DATA-1:0]         dst_hrdata;

    modport master (
        output src_haddr, src_hwrite, src_htrans, src_hsize, src_hprot, src_hwdata,
        input  src_hready, src_hresp, src_hrdata,
        input  dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hprot, dst_hburst,
        input  dst_hmastlock, dst_hwdata,
        output dst_hready, dst_hresp, dst_hrdata
    );

    modport slave (
        input  src_haddr, src_hwrite, src_htrans, src_hsize, src_hprot, src_hwdata,
        output src_hready, src_hresp, src_hrdata,
        output dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hprot, dst_hburst,
        output dst_hmastlock, dst_hwdata,
        input  dst_hready, dst_hresp, dst_hrdata
    );
endinterface

// File: rtl/hazard5_ahbl_arbiter.sv
// AHB-Lite N:1 arbiter with per-port address-phase skid buffers; fixed priority (port 0 first) by default,
// round-robin when HAZARD5_ARB_ROUND_ROBIN_EN is defined.
module hazard5_ahbl_arbiter_port #(
    parameter int PW = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          live_req_i,
    input  logic [PW-1:0] live_aph_i,
    input  logic          gnt_i,
    input  logic          owner_i,
    input  logic          dst_hready_i,
    output logic          req_o,
    output logic [PW-1:0] aph_o,
    output logic          src_hready_o
);
    logic          buf_valid_q, buf_valid_d;
    logic [PW-1:0] buf_aph_q, buf_aph_d;
    logic          buf_load, buf_clr;

    // Master saw HREADY high at the end of its data phase, so it believes this address was taken.
    assign buf_load = owner_i && dst_hready_i && live_req_i && !buf_valid_q && !gnt_i;
    assign buf_clr  = gnt_i && buf_valid_q && dst_hready_i;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_aph_d   = buf_aph_q;
        if (buf_load) begin
            buf_valid_d = 1'b1;
            buf_aph_d   = live_aph_i;
        end else if (buf_clr) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_aph_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_aph_q   <= buf_aph_d;
        end
    end

    assign req_o = buf_valid_q || live_req_i;
    assign aph_o = buf_valid_q ? buf_aph_q : live_aph_i;

    always_comb begin
        if (owner_i)          src_hready_o = dst_hready_i;
        else if (buf_valid_q) src_hready_o = 1'b0;
        else if (gnt_i)       src_hready_o = dst_hready_i;
        else if (live_req_i)  src_hready_o = 1'b0;
        else                  src_hready_o = 1'b1;
    end
endmodule

module hazard5_ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard5_ahbl_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [3:0]        prot;
    } aph_t;
    localparam int PW = $bits(aph_t);

    logic [N_PORTS-1:0] live_req, req, gnt, gnt_q, src_hready;
    logic [N_PORTS-1:0] dph_owner_q, dph_owner_d;
    logic               hold_aph_q, hold_aph_d;
    aph_t [N_PORTS-1:0] live_aph, eff_aph;
    aph_t               dst_aph;
    logic [W_DATA-1:0]  dph_wdata;
    logic               unused_htrans_seq;

    // Reset masks live requests so every output shows its reset value while rst is high.
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign live_req[i] = bus.src_htrans[2*i+1] && !rst;
        assign live_aph[i] = {bus.src_haddr[i*W_ADDR +: W_ADDR], bus.src_hwrite[i],
                              bus.src_hsize[3*i +: 3], bus.src_hprot[4*i +: 4]};

        hazard5_ahbl_arbiter_port #(.PW(PW)) u_port (
            .clk          (clk),
            .rst          (rst),
            .live_req_i   (live_req[i]),
            .live_aph_i   (live_aph[i]),
            .gnt_i        (gnt[i]),
            .owner_i      (dph_owner_q[i]),
            .dst_hready_i (bus.dst_hready),
            .req_o        (req[i]),
            .aph_o        (eff_aph[i]),
            .src_hready_o (src_hready[i])
        );
    end

    always_comb begin
        unused_htrans_seq = 1'b0;
        for (int k = 0; k < N_PORTS; k++) unused_htrans_seq = unused_htrans_seq ^ bus.src_htrans[2*k];
    end

`ifdef HAZARD5_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(N_PORTS);
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, srch_idx;

    always_comb begin
        gnt      = '0;
        srch_idx = '0;
        if (hold_aph_q) begin
            gnt = gnt_q;
        end else begin
            // Walk backwards so the port closest to rr_ptr_q is the last (winning) write.
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                srch_idx = PTR_W'((int'(rr_ptr_q) + k) % N_PORTS);
                if (req[srch_idx]) begin
                    gnt           = '0;
                    gnt[srch_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N_PORTS; k++) if (gnt[k]) gnt_idx = PTR_W'(k);
        rr_ptr_d = rr_ptr_q;
        if (|gnt && bus.dst_hready)
            rr_ptr_d = (int'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        gnt = '0;
        if (hold_aph_q) begin
            gnt = gnt_q;
        end else begin
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                if (req[k]) begin
                    gnt    = '0;
                    gnt[k] = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        dst_aph   = '0;
        dph_wdata = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (gnt[k])         dst_aph   = eff_aph[k];
            if (dph_owner_q[k]) dph_wdata = bus.src_hwdata[k*W_DATA +: W_DATA];
        end
    end

    // A stalled downstream address phase must stay put, so the grant is frozen until it is taken.
    assign hold_aph_d  = (|gnt) && !bus.dst_hready;
    assign dph_owner_d = bus.dst_hready ? gnt : dph_owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_aph_q  <= 1'b0;
            gnt_q       <= '0;
            dph_owner_q <= '0;
        end else begin
            hold_aph_q  <= hold_aph_d;
            gnt_q       <= gnt;
            dph_owner_q <= dph_owner_d;
        end
    end

    assign bus.dst_htrans    = {|gnt, 1'b0};
    assign bus.dst_haddr     = dst_aph.addr;
    assign bus.dst_hwrite    = dst_aph.write;
    assign bus.dst_hsize     = dst_aph.size;
    assign bus.dst_hprot     = dst_aph.prot;
    assign bus.dst_hburst    = 3'b000;
    assign bus.dst_hmastlock = 1'b0;
    assign bus.dst_hwdata    = dph_wdata;

    assign bus.src_hready = src_hready;
    assign bus.src_hresp  = dph_owner_q & {N_PORTS{bus.dst_hresp}};
    assign bus.src_hrdata = bus.dst_hrdata;
endmodule

// File: tb/tb_hazard5_ahbl_arbiter.sv
// Directed bench for hazard5_ahbl_arbiter: a transaction-level model checked every cycle at negedge,
// plus literal expectations for each scenario checked one delta after negedge.
module tb_hazard5_ahbl_arbiter;
    localparam int NP = 2;
`ifdef HAZARD5_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [2:0]  s;
        logic [3:0]  p;
    } aph_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    hazard5_ahbl_arbiter_if #(.N_PORTS(NP), .W_ADDR(32), .W_DATA(32)) bus ();

    hazard5_ahbl_arbiter #(.N_PORTS(NP), .W_ADDR(32), .W_DATA(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: pending (master-accepted, not yet issued) transfers per port
    int          m_owner = -1;
    int          m_held  = -1;
    int          m_rr    = 0;
    int          m_w;
    bit [NP-1:0] m_pend  = '0;
    aph_t        m_pay [NP];
    bit [NP-1:0] m_live, m_req, e_hr, e_resp;
    aph_t        m_aph;
    logic [31:0] e_wd;

    function automatic aph_t lp(input int i);
        return {bus.src_haddr[32*i +: 32], bus.src_hwrite[i], bus.src_hsize[3*i +: 3], bus.src_hprot[4*i +: 4]};
    endfunction

    function automatic int pick(input bit [NP-1:0] r, input int start);
        for (int k = 0; k < NP; k++) if (r[(start + k) % NP]) return (start + k) % NP;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_owner = -1; m_held = -1; m_rr = 0; m_pend = '0;
        end
        for (int i = 0; i < NP; i++) begin
            m_live[i] = !rst && bus.src_htrans[2*i+1];
            m_req[i]  = m_pend[i] || m_live[i];
        end
        m_w   = (m_held >= 0) ? m_held : pick(m_req, RR ? m_rr : 0);
        m_aph = '0;
        if (m_w >= 0) m_aph = m_pend[m_w] ? m_pay[m_w] : lp(m_w);
        for (int i = 0; i < NP; i++) begin
            // Data-phase owner follows downstream; otherwise ready only when nothing is outstanding.
            if (m_owner == i)   e_hr[i] = bus.dst_hready;
            else if (m_pend[i]) e_hr[i] = 1'b0;
            else if (m_live[i]) e_hr[i] = (m_w == i) && bus.dst_hready;
            else                e_hr[i] = 1'b1;
            e_resp[i] = bus.dst_hresp && (m_owner == i);
        end
        e_wd = (m_owner >= 0) ? bus.src_hwdata[32*m_owner +: 32] : 32'h0;

        chk("m_htrans", bus.dst_htrans, (m_w >= 0) ? 2'b10 : 2'b00);
        chk("m_haddr", bus.dst_haddr, m_aph.a);
        chk("m_hwrite", bus.dst_hwrite, m_aph.w);
        chk("m_hsize", bus.dst_hsize, m_aph.s);
        chk("m_hprot", bus.dst_hprot, m_aph.p);
        chk("m_hburst", bus.dst_hburst, 3'b000);
        chk("m_hmastlock", bus.dst_hmastlock, 1'b0);
        chk("m_hwdata", bus.dst_hwdata, e_wd);
        chk("m_src_hready", bus.src_hready, e_hr);
        chk("m_src_hresp", bus.src_hresp, e_resp);
        chk("m_src_hrdata", bus.src_hrdata, bus.dst_hrdata);

        // Advance to the state seen at the next rising edge (inputs are stable until then).
        for (int i = 0; i < NP; i++) begin
            if (m_pend[i] && m_w == i && bus.dst_hready)
                m_pend[i] = 1'b0;
            else if (e_hr[i] && m_live[i] && !(m_w == i && bus.dst_hready)) begin
                m_pend[i] = 1'b1;
                m_pay[i]  = lp(i);
            end
        end
        if (m_w >= 0 && bus.dst_hready) m_rr = (m_w + 1) % NP;
        m_held = (m_w >= 0 && !bus.dst_hready) ? m_w : -1;
        if (bus.dst_hready) m_owner = m_w;
    end

    // ---------------- stimulus
    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    task automatic drv(input int p, input bit on, input logic [31:0] a, input bit w);
        bus.src_htrans[2*p +: 2] = on ? 2'b10 : 2'b00;
        bus.src_haddr[32*p +: 32] = on ? a : 32'h0;
        bus.src_hwrite[p]         = on ? w : 1'b0;
        bus.src_hsize[3*p +: 3]   = on ? 3'(p + 1) : 3'd0;
        bus.src_hprot[4*p +: 4]   = on ? 4'(p + 2) : 4'd0;
    endtask

    initial begin
        drv(0, 0, 0, 0); drv(1, 0, 0, 0);
        bus.src_hwdata = {32'h1111_1111, 32'h0A0A_0A0A};
        bus.dst_hready = 1'b1; bus.dst_hresp = 1'b0; bus.dst_hrdata = 32'h0;

        mid();
        chk("rst_src_hready", bus.src_hready, 2'b11);
        chk("rst_htrans", bus.dst_htrans, 2'b00);
        chk("rst_hresp", bus.src_hresp, 2'b00);
        chk("rst_hwdata", bus.dst_hwdata, 32'h0);

        // single master read
        cyc(); rst = 1'b0; drv(0, 1, 32'h1000, 0);
        mid();
        chk("s1_haddr", bus.dst_haddr, 32'h1000);
        chk("s1_htrans", bus.dst_htrans, 2'b10);
        chk("s1_hready", bus.src_hready, 2'b11);
        cyc(); drv(0, 0, 0, 0); bus.dst_hrdata = 32'h1122_3344;
        mid();
        chk("s1_hrdata", bus.src_hrdata, 32'h1122_3344);
        chk("s1_hready0", bus.src_hready[0], 1'b1);

        // simultaneous requests
        cyc(); drv(0, 1, 32'h3000, 0); drv(1, 1, 32'h4000, 0);
        mid();
        chk("s2_first", bus.dst_haddr, RR ? 32'h4000 : 32'h3000);
        chk("s2_hready_a", bus.src_hready, RR ? 2'b10 : 2'b01);
        cyc();
        if (RR) drv(1, 0, 0, 0); else drv(0, 0, 0, 0);
        mid();
        chk("s2_second", bus.dst_haddr, RR ? 32'h3000 : 32'h4000);
        chk("s2_hready_b", bus.src_hready, 2'b11);
        cyc(); drv(0, 0, 0, 0); drv(1, 0, 0, 0);
        mid();
        chk("s2_idle", bus.dst_htrans, 2'b00);

        // port 0 data phase with 3 wait states while port 1 holds the grant; 0x2004 gets buffered
        cyc(); drv(0, 1, 32'h2000, 0);
        cyc(); drv(0, 0, 0, 0); drv(1, 1, 32'h5000, 0); bus.dst_hready = 1'b0;
        mid();
        chk("s3_hold_hready", bus.src_hready, 2'b00);
        cyc(); cyc();
        mid();
        chk("s3_held_addr", bus.dst_haddr, 32'h5000);
        cyc(); bus.dst_hready = 1'b1; bus.dst_hrdata = 32'hAAAA_0000; drv(0, 1, 32'h2004, 0);
        mid();
        chk("s3_done_addr", bus.dst_haddr, 32'h5000);
        chk("s3_done_hready", bus.src_hready, 2'b11);
        cyc(); drv(0, 0, 0, 0); drv(1, 0, 0, 0);
        mid();
        chk("s3_buf_addr", bus.dst_haddr, 32'h2004);
        chk("s3_buf_htrans", bus.dst_htrans, 2'b10);
        chk("s3_buf_hready", bus.src_hready, 2'b10);
        cyc(); bus.dst_hready = 1'b0;
        mid();
        chk("s3_wait_hready", bus.src_hready, 2'b10);
        cyc(); bus.dst_hready = 1'b1; bus.dst_hrdata = 32'hBBBB_2004;
        mid();
        chk("s3_end_hready", bus.src_hready, 2'b11);
        chk("s3_end_hrdata", bus.src_hrdata, 32'hBBBB_2004);

        // port 1 write with two-cycle error response
        cyc(); drv(1, 1, 32'h6000, 1);
        mid();
        chk("s4_hwrite", bus.dst_hwrite, 1'b1);
        chk("s4_haddr", bus.dst_haddr, 32'h6000);
        cyc(); drv(1, 0, 0, 0); bus.src_hwdata[63:32] = 32'hCAFE_F00D;
        bus.dst_hready = 1'b0; bus.dst_hresp = 1'b1;
        mid();
        chk("s4_hwdata", bus.dst_hwdata, 32'hCAFE_F00D);
        chk("s4_hresp_1", bus.src_hresp, 2'b10);
        chk("s4_hready_1", bus.src_hready, 2'b01);
        cyc(); bus.dst_hready = 1'b1;
        mid();
        chk("s4_hresp_2", bus.src_hresp, 2'b10);
        chk("s4_hready_2", bus.src_hready, 2'b11);
        cyc(); bus.dst_hresp = 1'b0;
        mid();
        chk("s4_hresp_end", bus.src_hresp, 2'b00);

        // reset in the middle of a stalled transfer
        cyc(); drv(0, 1, 32'h7000, 0);
        cyc(); drv(0, 1, 32'h7004, 0); drv(1, 1, 32'h8000, 0); bus.dst_hready = 1'b0;
        mid();
        chk("s5_pre_htrans", bus.dst_htrans, 2'b10);
        rst = 1'b1; #1;
        chk("s5_rst_htrans", bus.dst_htrans, 2'b00);
        chk("s5_rst_haddr", bus.dst_haddr, 32'h0);
        chk("s5_rst_hready", bus.src_hready, 2'b11);
        chk("s5_rst_hwdata", bus.dst_hwdata, 32'h0);
        chk("s5_rst_hresp", bus.src_hresp, 2'b00);
        cyc();
        cyc(); rst = 1'b0; bus.dst_hready = 1'b1; drv(0, 1, 32'h9000, 0); drv(1, 0, 0, 0);
        mid();
        chk("s5_post_haddr", bus.dst_haddr, 32'h9000);
        chk("s5_post_hready", bus.src_hready, 2'b11);
        cyc(); drv(0, 0, 0, 0);

        // both ports streaming
        cyc(); drv(0, 1, 32'hA000, 0); drv(1, 1, 32'hB000, 0);
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("stream_haddr", bus.dst_haddr, (RR && (k % 2 == 0)) ? 32'hB000 : 32'hA000);
            cyc();
        end
        drv(0, 0, 0, 0); drv(1, 0, 0, 0);
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
